// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word bus type, fetch FSM state encoding and the reset PC.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: JR beats Jump beats Branch beats sequential PC+4.
module pc_next
    import cpu_types_pkg::*;
(
    input  word_t       pc_plus4,
    input  logic [25:0] jtarget,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JR,
    input  word_t       br_off,
    input  word_t       jr_addr,
    output word_t       npc
);

    always_comb begin
        npc = pc_plus4;
        if (JR)
            npc = jr_addr;
        else if (Jump)
            npc = {pc_plus4[31:28], jtarget, 2'b00};
        else if (Branch)
            npc = pc_plus4 + (br_off << 2);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH/EXEC/HALTED sequencer, PC and instruction registers.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
//
// state  | meaning
// FETCH  | iREN high, waiting for ihit to latch imemload
// EXEC   | instr valid, waiting for retire (no data access, or dhit)
// HALTED | frozen until reset
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  dreq,
    input  logic  dhit,
    input  logic  halt,
    input  logic  Branch,
    input  logic  Jump,
    input  logic  JR,
    input  word_t br_off,
    input  word_t jr_addr,
    output logic  iREN,
    output word_t imemaddr,
    output word_t instr,
    output logic  instr_valid,
    output word_t pc_plus4
`ifdef FETCH_STALL_CNT_EN
    ,
    output word_t stall_cnt
`endif
);

    fetch_state_t state, state_nxt;
    word_t        pc, npc;
    logic         latch_instr, load_pc;

    assign imemaddr = pc;
    assign pc_plus4 = pc + 32'd4;

    pc_next u_pc_next (
        .pc_plus4 (pc_plus4),
        .jtarget  (instr[25:0]),
        .Branch   (Branch),
        .Jump     (Jump),
        .JR       (JR),
        .br_off   (br_off),
        .jr_addr  (jr_addr),
        .npc      (npc)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
            pc    <= PC_INIT;
            instr <= '0;
        end else begin
            state <= state_nxt;
            if (load_pc)
                pc <= npc;
            if (latch_instr)
                instr <= imemload;
        end
    end

    // halt is checked first so a coincident retire never moves the PC
    always_comb begin
        state_nxt   = state;
        iREN        = 1'b0;
        instr_valid = 1'b0;
        latch_instr = 1'b0;
        load_pc     = 1'b0;
        case (state)
            FETCH: begin
                iREN = 1'b1;
                if (halt) begin
                    state_nxt = HALTED;
                end else if (ihit) begin
                    latch_instr = 1'b1;
                    state_nxt   = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (halt) begin
                    state_nxt = HALTED;
                end else if (!dreq || dhit) begin
                    load_pc   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = FETCH;
        endcase
    end

`ifdef FETCH_STALL_CNT_EN
    logic stall_cyc;

    assign stall_cyc = ((state == FETCH) && !ihit) ||
                       ((state == EXEC) && dreq && !dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            stall_cnt <= '0;
        else if (stall_cyc && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  system clock, rising-edge active.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ihit  input  1  instruction memory returned imemload this cycle.
REQ-005 SHALL have port imemload  input  32  instruction word from memory.
REQ-006 SHALL have port dreq  input  1  current instruction is a data access (dread|dwrite from decode).
REQ-007 SHALL have port dhit  input  1  data access completed this cycle.
REQ-008 SHALL have port halt  input  1  latched halt from decode.
REQ-009 SHALL have port Branch, Jump, JR  input  1 each  next-PC select from decode.
REQ-010 SHALL have port br_off  input  32  sign-extended 16-bit branch offset, word units.
REQ-011 SHALL have port jr_addr  input  32  rs register value for JR.
REQ-012 SHALL have port iREN  output  1  instruction read request.
REQ-013 SHALL have port imemaddr  output  32  current PC.
REQ-014 SHALL have port instr  output  32  latched instruction; opcode/funct fields feed decode.
REQ-015 SHALL have port instr_valid  output  1  instr holds a fetched, unretired instruction.
REQ-016 SHALL have port pc_plus4  output  32  PC+4, for JAL link value.

Function
REQ-017 SHALL implement FSM states FETCH, EXEC, HALTED.
REQ-018 FETCH: iREN=1; on ihit latch imemload into instr, go EXEC; else stay.
REQ-019 EXEC: instr_valid=1, iREN=0; retire when (!dreq) or (dreq && dhit); on retire load next PC, go FETCH.
REQ-020 Next PC priority: JR -> jr_addr; else Jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else Branch -> pc_plus4 + (br_off<<2); else pc_plus4.
REQ-021 All PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-022 halt=1 in any state SHALL force HALTED next cycle; PC and instr frozen, iREN=0, instr_valid=0.
REQ-023 HALTED SHALL be exited only by reset.
REQ-024 halt and retire in same cycle: halt wins, PC not updated.
REQ-025 ihit in EXEC or HALTED SHALL be ignored.
REQ-026 Minimum latency per instruction: 2 cycles (FETCH with ihit, EXEC without dreq).

Reset
REQ-027 On nRST low: state=FETCH, PC=PC_INIT, instr=0, instr_valid=0, iREN=1 after release, imemaddr=PC_INIT.
REQ-028 Reset asserted mid-EXEC SHALL discard the in-flight instruction with no PC update.

Configuration
REQ-029 Macro FETCH_STALL_CNT_EN defined: SHALL add output stall_cnt (32) counting cycles in FETCH without ihit plus EXEC cycles with dreq && !dhit; saturates at 32'hFFFF_FFFF; cleared by reset; frozen in HALTED.
REQ-030 Macro undefined: stall_cnt port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 State enum (FETCH/EXEC/HALTED) and PC_INIT default constant SHALL live in cpu_types_pkg; word_t used for 32-bit buses.
REQ-032 Next-PC mux SHALL be a combinational sub-module pc_next; FSM, PC and instruction registers stay in fetch_unit.

Verification
REQ-033 Reset with PC_INIT=0, ihit=1 after 2 cycles -> imemaddr=0, iREN=1, instr latched on ihit, instr_valid=1 next cycle.
REQ-034 EXEC with Branch=1, br_off=32'hFFFF_FFFF, PC=0x10 -> next imemaddr=0x10.
REQ-035 EXEC with JR=1, Jump=1, jr_addr=0x200 -> next imemaddr=0x200 (JR priority).
REQ-036 dreq=1, dhit low 3 cycles -> PC held, instr_valid=1 for 4 cycles, retire on dhit; stall_cnt+=3 when FETCH_STALL_CNT_EN defined.
REQ-037 PC=0xFFFF_FFFC, no branch -> next imemaddr=0x0000_0000.
REQ-038 halt=1 coincident with dhit -> HALTED, PC unchanged, iREN=0 until nRST pulse, then imemaddr=PC_INIT.
